// File: rtl/nibble_serial_subtractor_if.sv
// Start/busy/done operand and result bundle for the digit-serial subtractor.
// The master drives the operands; the slave returns the difference and flags.
interface nibble_serial_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Z;
  logic             Sign;
  logic             Zero;
  logic             Carry;
  logic             Parity;
  logic             Overflow;

  modport master (
    output start, X, Y,
    input  busy, done, Z, Sign, Zero, Carry, Parity, Overflow
  );

  modport slave (
    input  start, X, Y,
    output busy, done, Z, Sign, Zero, Carry, Parity, Overflow
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial Z = X - Y: one DIGIT-wide slice of X + ~Y + c per clock, borrow rippled
// through a carry register, with adder-style flags registered on the final digit.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic                       clk,
  input logic                       rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic             r_busy;
  logic             r_done;
  logic             r_sign;
  logic             r_zero;
  logic             r_carry;
  logic             r_parity;
  logic             r_overflow;

  logic [DIGIT-1:0] w_x_dig;
  logic [DIGIT-1:0] w_y_dig;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_z_next;

  // Mux the active digit out and splice the new result digit back in.
  always_comb begin
    w_x_dig  = '0;
    w_y_dig  = '0;
    w_sum    = {1'b0, w_x_dig} + {1'b0, ~w_y_dig} + {{DIGIT{1'b0}}, r_c};
    w_z_next = r_z;
    for (int unsigned d = 0; d < NumDigits; d++) begin
      if (r_cnt == CntW'(d)) begin
        w_x_dig = r_x[d*DIGIT +: DIGIT];
        w_y_dig = r_y[d*DIGIT +: DIGIT];
      end
    end
    w_sum = {1'b0, w_x_dig} + {1'b0, ~w_y_dig} + {{DIGIT{1'b0}}, r_c};
    for (int unsigned d = 0; d < NumDigits; d++) begin
      if (r_cnt == CntW'(d)) begin
        w_z_next[d*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_c        <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_parity   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_x     <= bus.X;
            r_y     <= bus.Y;
            r_c     <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_z   <= w_z_next;
          r_c   <= w_sum[DIGIT];
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= StDone;
            r_sign     <= w_z_next[WIDTH-1];
            r_zero     <= (w_z_next == '0);
            r_carry    <= ~w_sum[DIGIT];
            r_parity   <= ~^w_z_next;
            r_overflow <= (r_x[WIDTH-1] & ~r_y[WIDTH-1] & ~w_z_next[WIDTH-1]) |
                          (~r_x[WIDTH-1] & r_y[WIDTH-1] & w_z_next[WIDTH-1]);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.Z        = r_z;
  assign bus.Sign     = r_sign;
  assign bus.Zero     = r_zero;
  assign bus.Carry    = r_carry;
  assign bus.Parity   = r_parity;
  assign bus.Overflow = r_overflow;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for the digit-serial subtractor: latency, flags, back-to-back and reset abort.
module tb_nibble_serial_subtractor;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) u_bus ();

  nibble_serial_subtractor #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_bus)
  );

  always #5 clk = ~clk;

  // Flags packed as {Sign, Zero, Carry, Parity, Overflow}.
  function automatic logic [4:0] flags();
    return {u_bus.Sign, u_bus.Zero, u_bus.Carry, u_bus.Parity, u_bus.Overflow};
  endfunction

  function automatic logic [22:0] all_outs();
    return {u_bus.busy, u_bus.done, u_bus.Z, flags()};
  endfunction

  // Drive one request so it is sampled by the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    u_bus.start = 1'b1;
    u_bus.X     = x;
    u_bus.Y     = y;
    @(posedge clk);
    #1;
    u_bus.start = 1'b0;
  endtask

  // Bounded wait for done; counts edges taken and samples where busy was high.
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!u_bus.done && edges < 10) begin
      if (u_bus.busy) busy_n++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    u_bus.start = 1'b1;
    u_bus.X     = 16'h0005;
    u_bus.Y     = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    u_bus.start = 1'b0;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (u_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority busy got %b want 0", u_bus.busy);
    end
  endtask

  task automatic test_basic();
    int edges, busy_n;
    issue(16'h0005, 16'h0003);
    wait_done(edges, busy_n);
    checks++;
    if (edges != 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", edges);
    end
    checks++;
    if (busy_n != 4) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 4", busy_n);
    end
    checks++;
    if (u_bus.Z !== 16'h0002) begin
      errors++;
      $display("FAIL basic_z got %h want 0002", u_bus.Z);
    end
    checks++;
    if (flags() !== 5'b00000) begin
      errors++;
      $display("FAIL basic_flags got %b want 00000", flags());
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_bus.done !== 1'b0 || u_bus.Z !== 16'h0002) begin
      errors++;
      $display("FAIL basic_pulse_hold got done=%b z=%h want done=0 z=0002", u_bus.done, u_bus.Z);
    end
  endtask

  task automatic test_flags();
    logic [15:0] tx[5] = '{16'h0003, 16'h8000, 16'h7FFF, 16'h1234, 16'hF000};
    logic [15:0] ty[5] = '{16'h0005, 16'h0001, 16'hFFFF, 16'h1234, 16'h0F00};
    logic [15:0] tz[5] = '{16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'hE100};
    logic [4:0]  tf[5] = '{5'b10100, 5'b00001, 5'b10101, 5'b01010, 5'b10010};
    int edges, busy_n;
    for (int i = 0; i < 5; i++) begin
      issue(tx[i], ty[i]);
      wait_done(edges, busy_n);
      checks++;
      if (edges != 4 || u_bus.Z !== tz[i]) begin
        errors++;
        $display("FAIL flags_z[%0d] got z=%h edges=%0d want z=%h edges=4", i, u_bus.Z, edges, tz[i]);
      end
      checks++;
      if (flags() !== tf[i]) begin
        errors++;
        $display("FAIL flags_szcpo[%0d] got %b want %b", i, flags(), tf[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_n;
    issue(16'h0005, 16'h0003);
    @(posedge clk);
    #1;
    u_bus.start = 1'b1;
    u_bus.X     = 16'hAAAA;
    u_bus.Y     = 16'h5555;
    @(posedge clk);
    #1;
    u_bus.start = 1'b0;
    wait_done(edges, busy_n);
    checks++;
    if (edges != 2 || u_bus.Z !== 16'h0002) begin
      errors++;
      $display("FAIL ignore_busy_start got z=%h edges=%0d want z=0002 edges=2", u_bus.Z, edges);
    end
    // Still in the DONE cycle: a new request here must be taken immediately.
    u_bus.start = 1'b1;
    u_bus.X     = 16'h0010;
    u_bus.Y     = 16'h0001;
    @(posedge clk);
    #1;
    u_bus.start = 1'b0;
    checks++;
    if (u_bus.busy !== 1'b1 || u_bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", u_bus.busy, u_bus.done);
    end
    wait_done(edges, busy_n);
    checks++;
    if (edges != 4 || u_bus.Z !== 16'h000F || flags() !== 5'b00010) begin
      errors++;
      $display("FAIL b2b_result got z=%h flags=%b edges=%0d want z=000f flags=00010 edges=4",
               u_bus.Z, flags(), edges);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int edges, busy_n;
    int done_seen;
    issue(16'hAAAA, 16'h5555);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (all_outs() !== 23'd0) begin
      errors++;
      $display("FAIL abort_outputs got %h want 0", all_outs());
    end
    done_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (u_bus.done || u_bus.busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active samples want 0", done_seen);
    end
    issue(16'h0100, 16'h0001);
    wait_done(edges, busy_n);
    checks++;
    if (edges != 4 || u_bus.Z !== 16'h00FF || flags() !== 5'b00010) begin
      errors++;
      $display("FAIL after_abort got z=%h flags=%b edges=%0d want z=00ff flags=00010 edges=4",
               u_bus.Z, flags(), edges);
    end
  endtask

  initial begin
    u_bus.start = 1'b0;
    u_bus.X     = '0;
    u_bus.Y     = '0;
    rst         = 1'b1;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor, the inverse of our combinational 16-bit adder/flag ALU. Computes Z = X - Y one 4-bit digit per clock, rippling the borrow across cycles.
- Produces the same flag set as the adder path: Sign, Zero, Carry, Parity, Overflow.
- Sits beside the ALU and serves area-constrained datapaths, using a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; latency in RUN = WIDTH/DIGIT cycles.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- X  input  WIDTH  minuend; captured on the accepting edge only.
- Y  input  WIDTH  subtrahend; captured on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; Z and flags valid from this cycle.
- Z  output  WIDTH  difference X - Y, modulo 2^WIDTH.
- Sign  output  1  Z[WIDTH-1].
- Zero  output  1  1 when Z == 0.
- Carry  output  1  borrow out: 1 when X < Y unsigned.
- Parity  output  1  even parity: ~^Z, i.e. 1 when Z has an even number of ones.
- Overflow  output  1  signed overflow: (X[msb] & ~Y[msb] & ~Z[msb]) | (~X[msb] & Y[msb] & Z[msb]).

Behaviour:
- Reset (rst high at an edge):
  - state goes to IDLE; digit counter, borrow and operand registers clear.
  - busy, done, Z, Sign, Zero, Carry, Parity, Overflow all go to 0.
  - rst has priority over start.
- States:
  - IDLE: start=1 latches X and Y, sets internal carry-in to 1 (two's-complement X + ~Y + 1), cnt=0, goes to RUN.
  - RUN: busy=1. Each edge computes digit cnt as Xr[d] + ~Yr[d] + c, writes it into the Z register slice d, updates c, and increments cnt.
  - RUN exit: on the edge that computes the last digit (cnt = WIDTH/DIGIT-1), state goes to DONE. On that same edge all five flags are registered from the final Z value, latched operand MSBs and final carry (Carry = ~c_final).
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE and goes to RUN (back-to-back issue); otherwise goes to IDLE.
- Latency: accepting edge N; digits computed at edges N+1 .. N+WIDTH/DIGIT (N+1..N+4 at defaults); done high in the cycle after edge N+4.
- Throughput: one result per WIDTH/DIGIT+1 cycles with back-to-back start.
- Z and flags:
  - Z updates digit by digit during RUN; it is only guaranteed valid while done=1 and afterwards.
  - Flags change only on the completion edge.
  - Z and flags hold their values in IDLE and DONE until the next operation's RUN.
- Input handling:
  - start is ignored while busy; X and Y changes after the accepting edge have no effect.
- Arithmetic:
  - Z is modulo 2^WIDTH; no saturation.
  - Carry and Overflow are independent.
- Reset mid-RUN: the operation is aborted, done never pulses, and all outputs read 0 after the reset edge.

Test Plan:
- 0x0005 - 0x0003 -> Z=0x0002, Carry=0, Zero=0, Sign=0, Parity=0, Overflow=0; done exactly 5 cycles after the accepting edge's cycle (one pulse); busy high 4 cycles.
- 0x0003 - 0x0005 -> Z=0xFFFE, Carry=1, Sign=1, Parity=0 (15 ones), Overflow=0, Zero=0.
- 0x8000 - 0x0001 -> Z=0x7FFF, Overflow=1, Sign=0, Carry=0; then 0x7FFF - 0xFFFF -> Z=0x8000, Overflow=1, Carry=1.
- 0x1234 - 0x1234 -> Z=0x0000, Zero=1, Parity=1, Carry=0, Overflow=0; 0xF000 - 0x0F00 -> Z=0xE100 (checks borrow across the digit boundary).
- start with 0x0005/0x0003, then start=1 with 0xAAAA/0x5555 on the second RUN cycle -> second request ignored, result 0x0002. Assert start during the DONE cycle with 0x0010 - 0x0001 -> accepted, next result Z=0x000F, Parity=1.
- Raise rst during the third RUN cycle -> all outputs 0 on the next edge, no done pulse. A following start 0x0100 - 0x0001 completes normally with Z=0x00FF, Parity=1.
